// File: rtl/spi_pkg.sv
// Register map of the SoC SPI master and state encodings shared by the burst sequencer.
package spi_pkg;

    localparam logic [7:0] SPI_REG_PRESCALE = 8'h00;
    localparam logic [7:0] SPI_REG_CS       = 8'h04;
    localparam logic [7:0] SPI_REG_DATA     = 8'h08;
    localparam logic [7:0] SPI_REG_MODE     = 8'h0C;

    typedef enum logic [2:0] {
        StIdle,
        StCsOn,
        StNext,
        StTxWait,
        StXfer,
        StRd,
        StRxPush,
        StCsOff
    } burst_state_e;

    typedef enum logic [1:0] {
        ReqIdle,
        ReqActive,
        ReqGap
    } req_state_e;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Command/TX/RX streams, status flags and SPI-master register port of spi_burst_ctrl.
interface spi_burst_ctrl_if #(
    parameter int unsigned CS_LENGTH = 32,
    parameter int unsigned LEN_W     = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CS_LENGTH-1:0] cmd_cs;
    logic [LEN_W-1:0]     cmd_len;
    logic                 cmd_rx_en;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 m_wr;
    logic                 m_rd;
    logic [7:0]           m_addr;
    logic [31:0]          m_wdat;
    logic [31:0]          m_rdat;
    logic                 m_done;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_cs, cmd_len, cmd_rx_en, tx_data, tx_valid, rx_ready,
               m_rdat, m_done,
        output cmd_ready, tx_ready, rx_data, rx_valid, busy, done, err,
               m_wr, m_rd, m_addr, m_wdat
    );

    // Firmware/DMA plus SPI master side.
    modport master (
        output cmd_valid, cmd_cs, cmd_len, cmd_rx_en, tx_data, tx_valid, rx_ready,
               m_rdat, m_done,
        input  cmd_ready, tx_ready, rx_data, rx_valid, busy, done, err,
               m_wr, m_rd, m_addr, m_wdat
    );
endinterface

// File: rtl/spi_reg_req.sv
// Holds one SPI-master register request until m_done, then forces a one-cycle idle gap.
// With SPI_BURST_TIMEOUT_EN a watchdog drops a request after TIMEOUT_CYCLES without m_done.
module spi_reg_req
    import spi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        req_wr,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdat,
    output logic        ack,
    output logic        timeout,
    output logic        m_wr,
    output logic        m_rd,
    output logic [7:0]  m_addr,
    output logic [31:0] m_wdat,
    input  logic        m_done
);

    req_state_e  state_q, state_d;
    logic        wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        expired;

`ifdef SPI_BURST_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (state_q == ReqActive && !m_done && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        ack     = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            ReqIdle: begin
                if (req) begin
                    state_d = ReqActive;
                    wr_d    = req_wr;
                    rd_d    = !req_wr;
                    addr_d  = req_addr;
                    wdat_d  = req_wr ? req_wdat : 32'h0;
                end
            end
            ReqActive: begin
                if (m_done || expired) begin
                    ack     = m_done;
                    timeout = !m_done;
                    state_d = ReqGap;
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                end
            end
            ReqGap:  state_d = ReqIdle;
            default: state_d = ReqIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ReqIdle;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= 8'h0;
            wdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
        end
    end

    assign m_wr   = wr_q;
    assign m_rd   = rd_q;
    assign m_addr = addr_q;
    assign m_wdat = wdat_q;

endmodule

// File: rtl/spi_burst_ctrl.sv
// Sequences one SPI burst command into CS-assert, per-byte write/readback and CS-release
// register accesses. Define SPI_BURST_TIMEOUT_EN to enable the m_done watchdog and err flag.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CS_LENGTH      = 32,
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic             clk,
    input logic             resetn,
    spi_burst_ctrl_if.slave bus
);

    burst_state_e         state_q, state_d;
    logic [CS_LENGTH-1:0] cs_q, cs_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic                 rx_en_q, rx_en_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic                 done_q, done_d;
    logic                 req, req_wr, ack, timeout;
    logic [7:0]           req_addr;
    logic [31:0]          req_wdat;
    logic                 cmd_ready, tx_ready, rx_valid;
    logic [23:0]          unused_rdat;

    assign unused_rdat = bus.m_rdat[31:8];

    spi_reg_req #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_reg_req (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .req_wr  (req_wr),
        .req_addr(req_addr),
        .req_wdat(req_wdat),
        .ack     (ack),
        .timeout (timeout),
        .m_wr    (bus.m_wr),
        .m_rd    (bus.m_rd),
        .m_addr  (bus.m_addr),
        .m_wdat  (bus.m_wdat),
        .m_done  (bus.m_done)
    );

    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        rem_d     = rem_q;
        rx_en_d   = rx_en_q;
        tx_byte_d = tx_byte_q;
        rx_byte_d = rx_byte_q;
        done_d    = 1'b0;
        req       = 1'b0;
        req_wr    = 1'b1;
        req_addr  = SPI_REG_CS;
        req_wdat  = 32'h0;
        cmd_ready = 1'b0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    cs_d    = bus.cmd_cs;
                    rem_d   = bus.cmd_len;
                    rx_en_d = bus.cmd_rx_en;
                    state_d = StCsOn;
                end
            end
            StCsOn: begin
                req      = 1'b1;
                req_wdat = 32'(~cs_q);
                if (ack) state_d = StNext;
                else if (timeout) state_d = StCsOff;
            end
            StNext: state_d = (rem_q == '0) ? StCsOff : StTxWait;
            StTxWait: begin
                tx_ready = 1'b1;
                if (bus.tx_valid) begin
                    tx_byte_d = bus.tx_data;
                    state_d   = StXfer;
                end
            end
            StXfer: begin
                req      = 1'b1;
                req_addr = SPI_REG_DATA;
                req_wdat = {24'h0, tx_byte_q};
                if (ack) begin
                    if (rx_en_q) begin
                        state_d = StRd;
                    end else begin
                        rem_d   = rem_q - 1'b1;
                        state_d = StNext;
                    end
                end else if (timeout) begin
                    state_d = StCsOff;
                end
            end
            StRd: begin
                req      = 1'b1;
                req_wr   = 1'b0;
                req_addr = SPI_REG_DATA;
                if (ack) begin
                    rx_byte_d = bus.m_rdat[7:0];
                    state_d   = StRxPush;
                end else if (timeout) begin
                    state_d = StCsOff;
                end
            end
            StRxPush: begin
                rx_valid = 1'b1;
                if (bus.rx_ready) begin
                    rem_d   = rem_q - 1'b1;
                    state_d = StNext;
                end
            end
            StCsOff: begin
                req      = 1'b1;
                req_wdat = 32'hFFFF_FFFF;
                // A second timeout here gives up and returns to idle anyway.
                if (ack || timeout) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cs_q      <= '0;
            rem_q     <= '0;
            rx_en_q   <= 1'b0;
            tx_byte_q <= 8'h0;
            rx_byte_q <= 8'h0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            rem_q     <= rem_d;
            rx_en_q   <= rx_en_d;
            tx_byte_q <= tx_byte_d;
            rx_byte_q <= rx_byte_d;
            done_q    <= done_d;
        end
    end

`ifdef SPI_BURST_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && bus.cmd_valid) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready;
    assign bus.tx_ready  = tx_ready;
    assign bus.rx_valid  = rx_valid;
    assign bus.rx_data   = rx_byte_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl with a loopback SPI-master model and random streams.
module tb_spi_burst_ctrl;
    import spi_pkg::*;

    localparam int unsigned CsLen    = 32;
    localparam int unsigned LenW     = 16;
    localparam int unsigned ToCycles = 16;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdat;
    } bus_op_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    spi_burst_ctrl_if #(.CS_LENGTH(CsLen), .LEN_W(LenW)) bus ();

    spi_burst_ctrl #(
        .CS_LENGTH     (CsLen),
        .LEN_W         (LenW),
        .TIMEOUT_CYCLES(ToCycles)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int          checks     = 0;
    int          failures   = 0;
    int          done_cnt   = 0;
    int          done_base  = 0;
    int          req_starts = 0;
    bus_op_t     exp_bus[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  fixed_bytes[$];
    bit          mute_all   = 1'b0;
    bit          mute_data  = 1'b0;
    bit          rx_stall   = 1'b0;
    bit          tx_seen    = 1'b0;
    bit          rx_seen    = 1'b0;
    logic [7:0]  last_addr  = 8'h0;
    logic [31:0] last_wdat  = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI master: random response latency, data register loops back the last written byte.
    initial begin : master_model
        bit         pending   = 1'b0;
        bit         just_done = 1'b0;
        bit         saw_both  = 1'b0;
        bit         unstable  = 1'b0;
        int         waited    = 0;
        int         lat       = 0;
        bus_op_t    cur;
        bus_op_t    e;
        logic [7:0] loop_byte = 8'h0;
        cur = '0;
        bus.m_done = 1'b0;
        bus.m_rdat = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_done = 1'b0;
            if (!resetn) begin
                pending   = 1'b0;
                just_done = 1'b0;
                continue;
            end
            if (just_done) begin
                check("gap_after_done", 32'(bus.m_wr | bus.m_rd), 32'h0);
                just_done = 1'b0;
                continue;
            end
            if (!(bus.m_wr || bus.m_rd)) begin
                pending = 1'b0;
                continue;
            end
            if (!pending) begin
                pending  = 1'b1;
                waited   = 0;
                lat      = int'($urandom_range(0, 3));
                saw_both = 1'b0;
                unstable = 1'b0;
                cur      = '{wr: bus.m_wr, addr: bus.m_addr, wdat: bus.m_wdat};
                req_starts++;
                last_addr = bus.m_addr;
                last_wdat = bus.m_wdat;
            end
            if (bus.m_wr && bus.m_rd) saw_both = 1'b1;
            if (bus.m_wr !== cur.wr || bus.m_addr !== cur.addr ||
                (cur.wr && bus.m_wdat !== cur.wdat)) unstable = 1'b1;
            if (mute_all || (mute_data && cur.addr == SPI_REG_DATA)) continue;
            if (waited < lat) begin
                waited++;
                continue;
            end
            bus.m_done = 1'b1;
            pending    = 1'b0;
            just_done  = 1'b1;
            if (!cur.wr) bus.m_rdat = {24'($urandom), loop_byte};
            else if (cur.addr == SPI_REG_DATA) loop_byte = cur.wdat[7:0];
            check("req_stable", 32'(unstable), 32'h0);
            check("no_wr_rd_overlap", 32'(saw_both), 32'h0);
            if (exp_bus.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_unexpected: got op wr=%0d addr=0x%0h expected none",
                         cur.wr, cur.addr);
            end else begin
                e = exp_bus.pop_front();
                check("bus_kind", 32'(cur.wr), 32'(e.wr));
                check("bus_addr", 32'(cur.addr), 32'(e.addr));
                if (e.wr) check("bus_wdat", cur.wdat, e.wdat);
            end
        end
    end

    initial begin : tx_driver
        bit fire;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h0;
        forever begin
            @(negedge clk);
            fire = bus.tx_valid && bus.tx_ready && resetn;
            if (bus.tx_ready) tx_seen = 1'b1;
            @(posedge clk);
            #1;
            if (fire && tx_q.size() > 0) void'(tx_q.pop_front());
            if (tx_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = tx_q[0];
            end else begin
                bus.tx_valid = 1'b0;
                bus.tx_data  = 8'($urandom);
            end
        end
    end

    initial begin : rx_driver
        bus.rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rx_ready = !rx_stall && ($urandom_range(0, 1) == 1);
        end
    end

    initial begin : rx_monitor
        forever begin
            @(negedge clk);
            if (bus.rx_valid) rx_seen = 1'b1;
            if (bus.done) done_cnt++;
            if (resetn && bus.rx_valid && bus.rx_ready) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected: got 0x%0h expected none", bus.rx_data);
                end else begin
                    check("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
                end
            end
        end
    end

    // Reference: CS write of ~cs, per byte a data write (+ read if rx_en), then CS release.
    task automatic issue_cmd(input logic [31:0] cs, input int len, input bit rx_en);
        logic [7:0] b;
        int         n;
        exp_bus.push_back('{wr: 1'b1, addr: SPI_REG_CS, wdat: ~cs});
        for (int i = 0; i < len; i++) begin
            b = (i < fixed_bytes.size()) ? fixed_bytes[i] : 8'($urandom);
            tx_q.push_back(b);
            exp_bus.push_back('{wr: 1'b1, addr: SPI_REG_DATA, wdat: {24'h0, b}});
            if (rx_en) begin
                exp_bus.push_back('{wr: 1'b0, addr: SPI_REG_DATA, wdat: 32'h0});
                exp_rx.push_back(b);
            end
        end
        exp_bus.push_back('{wr: 1'b1, addr: SPI_REG_CS, wdat: 32'hFFFF_FFFF});
        fixed_bytes.delete();
        done_base = done_cnt;
        tx_seen   = 1'b0;
        rx_seen   = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_cs    = cs;
        bus.cmd_len   = LenW'(len);
        bus.cmd_rx_en = rx_en;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("cmd_accept_in_time", 32'(bus.cmd_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_cs    = $urandom;
        bus.cmd_len   = LenW'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'h1);
    endtask

    task automatic wait_done(input string name, input int bound, input bit exp_err);
        int n = 0;
        while (done_cnt == done_base && n < bound) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_once"}, 32'(done_cnt - done_base), 32'h1);
        check({name, "_idle"}, 32'(bus.busy), 32'h0);
        check({name, "_bus_drained"}, 32'(exp_bus.size()), 32'h0);
        check({name, "_rx_drained"}, 32'(exp_rx.size()), 32'h0);
        check({name, "_tx_drained"}, 32'(tx_q.size()), 32'h0);
        check({name, "_err"}, 32'(bus.err), 32'(exp_err));
    endtask

    initial begin : main
        int         n;
        bit         bad;
        logic [7:0] d0;
        int         starts0;
        bus.cmd_valid = 1'b0;
        bus.cmd_cs    = '0;
        bus.cmd_len   = '0;
        bus.cmd_rx_en = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_outputs", {26'h0, bus.done, bus.err, bus.tx_ready, bus.rx_valid,
                              bus.m_wr, bus.m_rd}, 32'h0);
        check("rst_m_addr", 32'(bus.m_addr), 32'h0);
        check("rst_m_wdat", bus.m_wdat, 32'h0);
        check("rst_rx_data", 32'(bus.rx_data), 32'h0);
        resetn = 1'b1;

        // Two bytes with readback; command offered while busy must be refused.
        fixed_bytes = '{8'hA5, 8'h3C};
        issue_cmd(32'h1, 2, 1'b1);
        bus.cmd_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("cmd_ready_while_busy", 32'(bus.cmd_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_done("len2_rx", 500, 1'b0);

        issue_cmd(32'h4, 0, 1'b1);
        wait_done("len0", 200, 1'b0);
        check("len0_no_tx_ready", 32'(tx_seen), 32'h0);
        check("len0_no_rx_valid", 32'(rx_seen), 32'h0);

        issue_cmd(32'h0000_8001, 3, 1'b0);
        wait_done("len3_norx", 500, 1'b0);
        check("norx_no_rx_valid", 32'(rx_seen), 32'h0);

        // RX backpressure: burst must freeze with the first byte presented.
        rx_stall    = 1'b1;
        fixed_bytes = '{8'h5A, 8'hC3};
        issue_cmd(32'h2, 2, 1'b1);
        n = 0;
        @(negedge clk);
        while (!bus.rx_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("stall_rx_valid_seen", 32'(bus.rx_valid), 32'h1);
        d0      = bus.rx_data;
        starts0 = req_starts;
        bad     = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.rx_valid || bus.rx_data !== d0) bad = 1'b1;
        end
        check("stall_rx_held", 32'(bad), 32'h0);
        check("stall_no_new_req", 32'(req_starts - starts0), 32'h0);
        check("stall_first_byte", 32'(d0), 32'h5A);
        rx_stall = 1'b0;
        wait_done("stall", 500, 1'b0);

        for (int k = 0; k < 12; k++) begin
            issue_cmd($urandom, int'($urandom_range(0, 4)), 1'($urandom));
            wait_done("random", 1000, 1'b0);
        end

        // Reset while a data write is outstanding.
        mute_data = 1'b1;
        issue_cmd(32'h8, 2, 1'b1);
        n = 0;
        @(negedge clk);
        while (!(bus.m_wr && bus.m_addr == SPI_REG_DATA) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("xfer_reached", 32'(bus.m_wr && bus.m_addr == SPI_REG_DATA), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_req", {30'h0, bus.m_wr, bus.m_rd}, 32'h0);
        check("async_rst_m_addr", 32'(bus.m_addr), 32'h0);
        check("async_rst_m_wdat", bus.m_wdat, 32'h0);
        check("async_rst_ready_busy", {30'h0, bus.cmd_ready, bus.busy}, 32'h2);
        exp_bus.delete();
        exp_rx.delete();
        tx_q.delete();
        mute_data = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        issue_cmd(32'h10, 2, 1'b1);
        wait_done("post_rst", 500, 1'b0);

`ifdef SPI_BURST_TIMEOUT_EN
        // Silent master: CS_ON times out, one CS_OFF attempt also times out, then idle.
        mute_all = 1'b1;
        starts0  = req_starts;
        issue_cmd(32'h1, 1, 1'b0);
        exp_bus.delete();
        exp_rx.delete();
        tx_q.delete();
        n = 0;
        while (req_starts == starts0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (15) @(posedge clk);
        #1;
        check("to_err_not_yet", 32'(bus.err), 32'h0);
        @(posedge clk);
        #1;
        check("to_err_set", 32'(bus.err), 32'h1);
        wait_done("timeout", 200, 1'b1);
        check("to_csoff_addr", 32'(last_addr), 32'(SPI_REG_CS));
        check("to_csoff_wdat", last_wdat, 32'hFFFF_FFFF);
        mute_all = 1'b0;
        issue_cmd(32'h3, 1, 1'b1);
        check("err_cleared_on_accept", 32'(bus.err), 32'h0);
        wait_done("after_timeout", 500, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
